mem_txn_fsm: RTL and testbench

//  Flash transaction sequencer sitting directly upstream of spi_controller.

---
 rtl/mem_txn_if.sv | 55 +++++
 rtl/mem_txn_fsm.sv | 300 ++++++++++++++++++++++++++++++
 tb/tb_mem_txn_fsm.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_txn_if.sv
// mem_txn_if: request, payload and spi_controller byte handshakes of the
// flash transaction sequencer, bundled into one interface.
//   master : the sequencer (mem_txn_fsm)
//   slave  : the requester plus spi_controller side
interface mem_txn_if #(
    parameter int LEN_W = 9
);
    // request channel
    logic             req_valid;
    logic             req_ready;
    logic             req_write;
    logic [23:0]      req_addr;
    logic [LEN_W-1:0] req_len;
    // write payload
    logic             wr_valid;
    logic [7:0]       wr_data;
    logic             wr_ready;
    // read payload
    logic             rd_valid;
    logic [7:0]       rd_data;
    logic             rd_ready;
    // status
    logic             busy;
    logic             done;
    logic             err;
    // spi_controller side
    logic             spi_start;
    logic [15:0]      spi_num_bytes;
    logic             spi_busy;
    logic             spi_done;
    logic             spi_tx_valid;
    logic [7:0]       spi_tx_data;
    logic             spi_tx_ready;
    logic             spi_rx_valid;
    logic [7:0]       spi_rx_data;
    logic             spi_rx_ready;

    modport master (
        input  req_valid, req_write, req_addr, req_len,
        input  wr_valid, wr_data, rd_ready,
        input  spi_busy, spi_done, spi_tx_ready, spi_rx_valid, spi_rx_data,
        output req_ready, wr_ready, rd_valid, rd_data,
        output busy, done, err,
        output spi_start, spi_num_bytes, spi_tx_valid, spi_tx_data, spi_rx_ready
    );

    modport slave (
        output req_valid, req_write, req_addr, req_len,
        output wr_valid, wr_data, rd_ready,
        output spi_busy, spi_done, spi_tx_ready, spi_rx_valid, spi_rx_data,
        input  req_ready, wr_ready, rd_valid, rd_data,
        input  busy, done, err,
        input  spi_start, spi_num_bytes, spi_tx_valid, spi_tx_data, spi_rx_ready
    );
endinterface

// File: rtl/mem_txn_fsm.sv
// mem_txn_fsm: flash transaction sequencer in front of spi_controller.
// Turns one read/write request into READ (0x03) or WREN (0x06) + PAGE
// PROGRAM (0x02) + RDSR (0x05) busy-poll command sequences and streams the
// payload between the requester and the controller byte handshakes.
// Optional feature: define MEM_POLL_TIMEOUT_EN to give up after MAX_POLLS
// busy RDSR results (err=1); otherwise polling continues until SR[0]=0.
module mem_txn_fsm #(
    parameter int LEN_W     = 9,
    parameter int MAX_POLLS = 4096
) (
    input logic       clk,
    input logic       rst,
    mem_txn_if.master bus
);
    localparam int CNT_W = LEN_W + 3;

    if (MAX_POLLS < 1) begin : g_bad_max_polls
        $error("MAX_POLLS must be at least 1");
    end

    typedef enum logic [3:0] {
        IDLE, WREN_GO, WREN_WAIT, CMD_GO, HDR, DATA, CMD_WAIT, POLL_GO, POLL_WAIT, FIN
    } state_t;

    state_t           state;
    logic             is_write;
    logic [23:0]      addr;
    logic [LEN_W-1:0] len;
    logic [CNT_W-1:0] len_ext;
    logic [CNT_W-1:0] tx_cnt;
    logic [CNT_W-1:0] rx_cnt;
    logic             sr_busy;
    logic             sr_now;
    logic             req_ready_r;
    logic             busy_r;
    logic             done_r;
    logic             err_r;
    logic             start_r;
    logic [15:0]      num_r;
    logic [7:0]       hdr_byte;
    logic             req_fire;
    logic             tx_fire;
    logic             rx_fire;
    logic             tx_last;
    logic             poll_sent;

`ifdef MEM_POLL_TIMEOUT_EN
    localparam int POLL_W = $clog2(MAX_POLLS) + 1;
    logic [POLL_W-1:0] poll_cnt;
`endif

    assign bus.req_ready     = req_ready_r;
    assign bus.busy          = busy_r;
    assign bus.done          = done_r;
    assign bus.err           = err_r;
    assign bus.spi_start     = start_r;
    assign bus.spi_num_bytes = num_r;

    assign len_ext   = CNT_W'(len);
    assign req_fire  = bus.req_valid && req_ready_r;
    assign tx_fire   = bus.spi_tx_valid && bus.spi_tx_ready;
    assign rx_fire   = bus.spi_rx_valid && bus.spi_rx_ready;
    assign tx_last   = (tx_cnt + CNT_W'(1)) == len_ext;
    // both RDSR bytes are out once the count reaches 2 or the second one is leaving now
    assign poll_sent = (tx_cnt == CNT_W'(2)) || ((tx_cnt == CNT_W'(1)) && tx_fire);
    // the status byte may land in the same cycle as spi_done
    assign sr_now    = (rx_fire && rx_cnt == CNT_W'(1)) ? bus.spi_rx_data[0] : sr_busy;

    // Command/address header byte selected by position within the header
    always_comb begin
        hdr_byte = 8'h00;
        case (tx_cnt[1:0])
            2'd0:    hdr_byte = is_write ? 8'h02 : 8'h03;
            2'd1:    hdr_byte = addr[23:16];
            2'd2:    hdr_byte = addr[15:8];
            default: hdr_byte = addr[7:0];
        endcase
    end

    // Byte-stream steering: tx source per state, rx drop vs. read pass-through
    always_comb begin
        bus.spi_tx_valid = 1'b0;
        bus.spi_tx_data  = 8'h00;
        bus.wr_ready     = 1'b0;
        bus.rd_valid     = 1'b0;
        bus.rd_data      = 8'h00;
        bus.spi_rx_ready = 1'b0;
        case (state)
            WREN_WAIT: begin
                bus.spi_tx_valid = (tx_cnt == '0);
                bus.spi_tx_data  = 8'h06;
                bus.spi_rx_ready = 1'b1;
            end
            HDR: begin
                bus.spi_tx_valid = 1'b1;
                bus.spi_tx_data  = hdr_byte;
            end
            DATA: begin
                if (is_write) begin
                    bus.spi_tx_valid = bus.wr_valid;
                    bus.spi_tx_data  = bus.wr_data;
                    bus.wr_ready     = bus.spi_tx_ready;
                end else begin
                    bus.spi_tx_valid = 1'b1;
                    bus.spi_tx_data  = 8'h00;
                end
            end
            POLL_WAIT: begin
                bus.spi_tx_valid = (tx_cnt < CNT_W'(2));
                bus.spi_tx_data  = (tx_cnt == '0) ? 8'h05 : 8'h00;
                bus.spi_rx_ready = 1'b1;
            end
            default: ;
        endcase
        // during the main command the first 4 rx bytes echo the header and are dropped
        if (state == HDR || state == DATA || state == CMD_WAIT) begin
            if (is_write || rx_cnt < CNT_W'(4)) begin
                bus.spi_rx_ready = 1'b1;
            end else begin
                bus.rd_valid     = bus.spi_rx_valid;
                bus.rd_data      = bus.spi_rx_data;
                bus.spi_rx_ready = bus.rd_ready;
            end
        end
    end

    // Request fields and RDSR status bit (data path, no reset)
    always_ff @(posedge clk) begin
        if (req_fire) begin
            addr <= bus.req_addr;
            len  <= bus.req_len;
        end
        if (rx_fire && rx_cnt == CNT_W'(1)) begin
            sr_busy <= bus.spi_rx_data[0];
        end
    end

    // Transaction sequencer with registered control outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            is_write    <= 1'b0;
            tx_cnt      <= '0;
            rx_cnt      <= '0;
            req_ready_r <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            err_r       <= 1'b0;
            start_r     <= 1'b0;
            num_r       <= 16'h0000;
`ifdef MEM_POLL_TIMEOUT_EN
            poll_cnt    <= '0;
`endif
        end else begin
            start_r <= 1'b0;
            done_r  <= 1'b0;
            if (rx_fire) begin
                rx_cnt <= rx_cnt + CNT_W'(1);
            end
            case (state)
                IDLE: begin
                    req_ready_r <= 1'b1;
                    if (req_fire) begin
                        req_ready_r <= 1'b0;
                        busy_r      <= 1'b1;
                        err_r       <= 1'b0;
                        is_write    <= bus.req_write;
`ifdef MEM_POLL_TIMEOUT_EN
                        poll_cnt    <= '0;
`endif
                        if (bus.req_len == '0) begin
                            done_r <= 1'b1;
                            state  <= FIN;
                        end else if (bus.req_write && (32'(bus.req_len) > 32'd256)) begin
                            err_r  <= 1'b1;
                            done_r <= 1'b1;
                            state  <= FIN;
                        end else if (bus.req_write) begin
                            state <= WREN_GO;
                        end else begin
                            state <= CMD_GO;
                        end
                    end
                end
                WREN_GO: begin
                    if (!bus.spi_busy) begin
                        start_r <= 1'b1;
                        num_r   <= 16'd1;
                        tx_cnt  <= '0;
                        rx_cnt  <= '0;
                        state   <= WREN_WAIT;
                    end
                end
                WREN_WAIT: begin
                    if (tx_fire) begin
                        tx_cnt <= tx_cnt + CNT_W'(1);
                    end
                    if (bus.spi_done) begin
                        if (tx_cnt != '0 || tx_fire) begin
                            state <= CMD_GO;
                        end else begin
                            err_r  <= 1'b1;
                            done_r <= 1'b1;
                            state  <= FIN;
                        end
                    end
                end
                CMD_GO: begin
                    if (!bus.spi_busy) begin
                        start_r <= 1'b1;
                        num_r   <= 16'(len) + 16'd4;
                        tx_cnt  <= '0;
                        rx_cnt  <= '0;
                        state   <= HDR;
                    end
                end
                HDR: begin
                    if (tx_fire) begin
                        tx_cnt <= tx_cnt + CNT_W'(1);
                    end
                    if (tx_fire && tx_cnt == CNT_W'(3)) begin
                        tx_cnt <= '0;
                        state  <= DATA;
                    end else if (bus.spi_done) begin
                        err_r  <= 1'b1;
                        done_r <= 1'b1;
                        state  <= FIN;
                    end
                end
                DATA: begin
                    if (tx_fire) begin
                        tx_cnt <= tx_cnt + CNT_W'(1);
                    end
                    if (tx_fire && tx_last) begin
                        state <= CMD_WAIT;
                    end else if (bus.spi_done) begin
                        err_r  <= 1'b1;
                        done_r <= 1'b1;
                        state  <= FIN;
                    end
                end
                CMD_WAIT: begin
                    if (bus.spi_done) begin
                        if (is_write) begin
                            state <= POLL_GO;
                        end else begin
                            done_r <= 1'b1;
                            state  <= FIN;
                        end
                    end
                end
                POLL_GO: begin
                    if (!bus.spi_busy) begin
                        start_r <= 1'b1;
                        num_r   <= 16'd2;
                        tx_cnt  <= '0;
                        rx_cnt  <= '0;
                        state   <= POLL_WAIT;
                    end
                end
                POLL_WAIT: begin
                    if (tx_fire) begin
                        tx_cnt <= tx_cnt + CNT_W'(1);
                    end
                    if (bus.spi_done) begin
                        if (!poll_sent) begin
                            err_r  <= 1'b1;
                            done_r <= 1'b1;
                            state  <= FIN;
                        end else if (sr_now) begin
`ifdef MEM_POLL_TIMEOUT_EN
                            if (poll_cnt == POLL_W'(MAX_POLLS - 1)) begin
                                err_r  <= 1'b1;
                                done_r <= 1'b1;
                                state  <= FIN;
                            end else begin
                                poll_cnt <= poll_cnt + POLL_W'(1);
                                state    <= POLL_GO;
                            end
`else
                            state <= POLL_GO;
`endif
                        end else begin
                            done_r <= 1'b1;
                            state  <= FIN;
                        end
                    end
                end
                FIN: begin
                    busy_r      <= 1'b0;
                    req_ready_r <= 1'b1;
                    state       <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_txn_fsm.sv
// tb_mem_txn_fsm: directed scoreboard bench for mem_txn_fsm with a small
// behavioural spi_controller model. Expected SPI bytes, transaction sizes,
// read bytes and done/err outcomes are queued by the stimulus and popped by
// an independent monitor.
module tb_mem_txn_fsm;
    localparam int LEN_W = 9;
`ifdef MEM_POLL_TIMEOUT_EN
    localparam int MAX_POLLS = 3;
`else
    localparam int MAX_POLLS = 4096;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    bit   rd_toggle = 1'b0;

    logic [7:0] exp_tx[$];
    int         exp_nb[$];
    logic [7:0] exp_rd[$];
    bit         exp_err[$];
    logic [7:0] rx_script[$];
    logic [7:0] wr_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_txn_if #(.LEN_W(LEN_W)) bus ();

    mem_txn_fsm #(.LEN_W(LEN_W), .MAX_POLLS(MAX_POLLS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name);
        checks++;
        errors++;
        $display("FAIL %s: event seen, expected none", name);
    endtask

    // write payload source
    initial begin : wr_drv
        bus.wr_valid = 1'b0;
        bus.wr_data  = 8'h00;
        forever begin
            @(negedge clk);
            bus.wr_valid = (wr_q.size() > 0);
            bus.wr_data  = (wr_q.size() > 0) ? wr_q[0] : 8'h00;
            #1;
            if (bus.wr_valid && bus.wr_ready) void'(wr_q.pop_front());
        end
    end

    // read sink: always ready, or a 1-0-1 pattern when rd_toggle is set
    initial begin : rd_drv
        bus.rd_ready = 1'b1;
        forever begin
            @(negedge clk);
            bus.rd_ready = !rd_toggle || ((cyc % 3) != 1);
        end
    end

    // spi_controller model: one tx byte, then its rx byte, then done after num_bytes
    initial begin : spi_model
        int nb;
        int sent;
        bit active;
        bit rx_pend;
        bit done_pend;
        logic [7:0] rx_byte;
        nb = 0; sent = 0; active = 0; rx_pend = 0; done_pend = 0; rx_byte = 8'h00;
        bus.spi_busy = 1'b0; bus.spi_done = 1'b0; bus.spi_tx_ready = 1'b0;
        bus.spi_rx_valid = 1'b0; bus.spi_rx_data = 8'h00;
        forever begin
            @(negedge clk);
            if (rst) begin
                active = 0; rx_pend = 0; done_pend = 0;
                bus.spi_busy = 1'b0; bus.spi_done = 1'b0; bus.spi_tx_ready = 1'b0;
                bus.spi_rx_valid = 1'b0; bus.spi_rx_data = 8'h00;
            end else begin
                bus.spi_busy     = active;
                bus.spi_done     = done_pend;
                bus.spi_tx_ready = active && !done_pend && !rx_pend && (sent < nb);
                bus.spi_rx_valid = rx_pend;
                bus.spi_rx_data  = rx_pend ? rx_byte : 8'h00;
                #1;
                if (done_pend) begin
                    done_pend = 0;
                    active    = 0;
                end else if (active) begin
                    if (bus.spi_tx_valid && bus.spi_tx_ready) begin
                        sent++;
                        rx_pend = 1;
                        rx_byte = (rx_script.size() > 0) ? rx_script.pop_front() : 8'hFF;
                    end else if (rx_pend && bus.spi_rx_ready) begin
                        rx_pend = 0;
                    end
                    if (!rx_pend && sent == nb) done_pend = 1;
                end else if (bus.spi_start) begin
                    active = 1;
                    nb     = int'(bus.spi_num_bytes);
                    sent   = 0;
                end
            end
        end
    end

    // monitor: pops expectations whenever the DUT presents an output event
    initial begin : monitor
        forever begin
            @(negedge clk);
            #2;
            if (bus.spi_start) begin
                if (exp_nb.size() == 0) unexpected("spi_start");
                else chk("spi_num_bytes", 32'(bus.spi_num_bytes), 32'(exp_nb.pop_front()));
            end
            if (bus.spi_tx_valid && bus.spi_tx_ready) begin
                if (exp_tx.size() == 0) unexpected("spi_tx_byte");
                else chk("spi_tx_data", 32'(bus.spi_tx_data), 32'(exp_tx.pop_front()));
            end
            if (bus.rd_valid) begin
                chk("rx_ready_follows_rd_ready", 32'(bus.spi_rx_ready), 32'(bus.rd_ready));
                if (bus.rd_ready) begin
                    if (exp_rd.size() == 0) unexpected("rd_byte");
                    else chk("rd_data", 32'(bus.rd_data), 32'(exp_rd.pop_front()));
                end
            end
            if (bus.done) begin
                if (exp_err.size() == 0) unexpected("done");
                else chk("err_at_done", 32'(bus.err), 32'(exp_err.pop_front()));
            end
        end
    end

    task automatic issue(input bit wr, input logic [23:0] a, input int len);
        int n;
        n = 0;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_write = wr;
        bus.req_addr  = a;
        bus.req_len   = LEN_W'(len);
        #1;
        while (!bus.req_ready && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("req_accepted", 32'(bus.req_ready), 32'd1);
        @(negedge clk);
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_done(input string name, input int max);
        bit seen;
        seen = 0;
        for (int i = 0; i < max && !seen; i++) begin
            @(negedge clk);
            #1;
            if (bus.done) seen = 1;
        end
        chk(name, 32'(seen), 32'd1);
        repeat (2) @(negedge clk);
    endtask

    task automatic push_tx(input logic [7:0] b[]);
        foreach (b[i]) exp_tx.push_back(b[i]);
    endtask

    task automatic push_rx(input logic [7:0] b[]);
        foreach (b[i]) rx_script.push_back(b[i]);
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // directed stimulus
    initial begin : stim
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_addr  = 24'h0;
        bus.req_len   = '0;
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("reset_outputs",
            {bus.req_ready, bus.busy, bus.done, bus.err, bus.spi_start, bus.spi_tx_valid,
             bus.wr_ready, bus.rd_valid, bus.spi_rx_ready, 7'd0, bus.spi_num_bytes}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #1;
        chk("req_ready_after_reset", 32'(bus.req_ready), 32'd1);

        // READ 0x123456, 3 bytes
        exp_nb.push_back(7);
        push_tx('{8'h03, 8'h12, 8'h34, 8'h56, 8'h00, 8'h00, 8'h00});
        push_rx('{8'hF0, 8'hF1, 8'hF2, 8'hF3, 8'hAA, 8'hBB, 8'hCC});
        exp_rd.push_back(8'hAA); exp_rd.push_back(8'hBB); exp_rd.push_back(8'hCC);
        exp_err.push_back(1'b0);
        issue(1'b0, 24'h123456, 3);
        wait_done("read3_done", 200);
        chk("read3_rd_drained", 32'(exp_rd.size()), 32'd0);

        // WRITE 0x000100, 5A A5, SR busy twice then ready
        exp_nb.push_back(1); exp_nb.push_back(6);
        exp_nb.push_back(2); exp_nb.push_back(2); exp_nb.push_back(2);
        push_tx('{8'h06, 8'h02, 8'h00, 8'h01, 8'h00, 8'h5A, 8'hA5,
                  8'h05, 8'h00, 8'h05, 8'h00, 8'h05, 8'h00});
        push_rx('{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                  8'h00, 8'h01, 8'h00, 8'h01, 8'h00, 8'h00});
        wr_q.push_back(8'h5A); wr_q.push_back(8'hA5);
        exp_err.push_back(1'b0);
        issue(1'b1, 24'h000100, 2);
        wait_done("write2_done", 400);
        chk("write2_tx_drained", 32'(exp_tx.size()), 32'd0);

        // READ 0x00ABCD, 4 bytes with rd_ready toggling
        rd_toggle = 1'b1;
        exp_nb.push_back(8);
        push_tx('{8'h03, 8'h00, 8'hAB, 8'hCD, 8'h00, 8'h00, 8'h00, 8'h00});
        push_rx('{8'hE0, 8'hE1, 8'hE2, 8'hE3, 8'h11, 8'h22, 8'h33, 8'h44});
        exp_rd.push_back(8'h11); exp_rd.push_back(8'h22);
        exp_rd.push_back(8'h33); exp_rd.push_back(8'h44);
        exp_err.push_back(1'b0);
        issue(1'b0, 24'h00ABCD, 4);
        wait_done("read4_bp_done", 300);
        chk("read4_bp_rd_drained", 32'(exp_rd.size()), 32'd0);
        rd_toggle = 1'b0;

        // WRITE with 300 bytes: immediate error, no SPI traffic
        exp_err.push_back(1'b1);
        issue(1'b1, 24'h000000, 300);
        #1;
        chk("len300_done_next_cycle", 32'(bus.done), 32'd1);
        repeat (3) @(negedge clk);
        #1;
        chk("len300_err_sticky", 32'(bus.err), 32'd1);

        // READ with 0 bytes: done, err cleared by the new request
        exp_err.push_back(1'b0);
        issue(1'b0, 24'h000000, 0);
        #1;
        chk("len0_done_next_cycle", 32'(bus.done), 32'd1);
        chk("len0_err_cleared", 32'(bus.err), 32'd0);
        repeat (3) @(negedge clk);

        // reset while a WRITE is stalled in its payload phase
        exp_nb.push_back(1); exp_nb.push_back(8);
        push_tx('{8'h06, 8'h02, 8'h00, 8'h02, 8'h00, 8'h77});
        wr_q.push_back(8'h77);
        issue(1'b1, 24'h000200, 4);
        for (int i = 0; i < 300 && (exp_tx.size() != 0 || wr_q.size() != 0); i++) @(negedge clk);
        chk("abort_payload_started", 32'(exp_tx.size()), 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort_outputs_zero",
            {bus.req_ready, bus.busy, bus.done, bus.err, bus.spi_start, bus.spi_tx_valid,
             bus.wr_ready, bus.rd_valid, bus.spi_rx_ready, 7'd0, bus.spi_num_bytes}, 32'd0);
        exp_nb.delete(); exp_tx.delete(); rx_script.delete(); wr_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #1;
        chk("abort_req_ready", 32'(bus.req_ready), 32'd1);
        repeat (5) @(negedge clk);

`ifdef MEM_POLL_TIMEOUT_EN
        // SR stuck busy: exactly MAX_POLLS RDSR transactions then error
        exp_nb.push_back(1); exp_nb.push_back(5);
        exp_nb.push_back(2); exp_nb.push_back(2); exp_nb.push_back(2);
        push_tx('{8'h06, 8'h02, 8'h00, 8'h00, 8'h00, 8'h33,
                  8'h05, 8'h00, 8'h05, 8'h00, 8'h05, 8'h00});
        push_rx('{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                  8'h00, 8'h01, 8'h00, 8'h01, 8'h00, 8'h01});
        wr_q.push_back(8'h33);
        exp_err.push_back(1'b1);
        issue(1'b1, 24'h000000, 1);
        wait_done("poll_timeout_done", 400);
        repeat (10) @(negedge clk);
`endif

        chk("all_expectations_consumed",
            32'(exp_tx.size() + exp_nb.size() + exp_rd.size() + exp_err.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
